// File: rtl/exe_stage_pipelined_if.sv
// ID -> EX instruction bundle and back-pressure (stall) from the execute stage.
// master = decode stage, slave = execute stage.
interface exe_stage_pipelined_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  stall;
    logic [DATA_WIDTH-1:0] pc;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic                  wb_en;
    logic                  immediate;
    logic                  carry_in;
    logic [11:0]           shift_operand;
    logic [3:0]            alu_ctrl;
    logic                  mul;
    logic                  accumulate;
    logic [DATA_WIDTH-1:0] val_rm;
    logic [DATA_WIDTH-1:0] val_rn;
    logic [DATA_WIDTH-1:0] val_rs;
    logic [23:0]           imm24;
    logic [3:0]            dest;
    logic [1:0]            sel_src1;
    logic [1:0]            sel_src2;

    modport master (
        output valid, pc, mem_read_en, mem_write_en, wb_en, immediate, carry_in,
               shift_operand, alu_ctrl, mul, accumulate, val_rm, val_rn, val_rs,
               imm24, dest, sel_src1, sel_src2,
        input  stall
    );

    modport slave (
        input  valid, pc, mem_read_en, mem_write_en, wb_en, immediate, carry_in,
               shift_operand, alu_ctrl, mul, accumulate, val_rm, val_rn, val_rs,
               imm24, dest, sel_src1, sel_src2,
        output stall
    );
endinterface

// File: rtl/exe_stage_pipelined.sv
// Execute stage with EX/MEM register. Define EXE_STAGE_MUL_EN to add the iterative
// shift-add MUL/MLA unit (stalls ID while busy); otherwise every op is a 1-cycle ALU op.
module exe_stage_pipelined #(
    parameter int DATA_WIDTH         = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    exe_stage_pipelined_if.slave  id_if,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] mem_fwd_value_i,
    input  logic [DATA_WIDTH-1:0] wb_fwd_value_i,
    output logic [DATA_WIDTH-1:0] branch_address_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  mem_read_en_o,
    output logic                  mem_write_en_o,
    output logic                  wb_en_o,
    output logic [3:0]            dest_o,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [3:0]            alu_status_o,
    output logic [DATA_WIDTH-1:0] val_rm_o
);
    localparam int DW = DATA_WIDTH;
    localparam logic [3:0] OP_MOV = 4'b0001, OP_MVN = 4'b1001, OP_ADD = 4'b0010,
                           OP_ADC = 4'b0011, OP_SUB = 4'b0100, OP_SBC = 4'b0101,
                           OP_AND = 4'b0110, OP_ORR = 4'b0111, OP_EOR = 4'b1000;

    logic [DW-1:0] rn_fwd, rm_fwd, val2, alu_res, add_b;
    logic [DW:0]   add_sum;
    logic          add_cin, alu_c, alu_v, stall, accept;
    logic [3:0]    alu_flags;

    logic          valid_q, mem_read_en_q, mem_write_en_q, wb_en_q;
    logic [DW-1:0] pc_q, result_q, val_rm_q;
    logic [3:0]    dest_q, status_q;

    function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input int unsigned amt);
        int unsigned r;
        r = amt % DW;
        return (x >> r) | (x << (DW - r));
    endfunction

    assign branch_address_o = id_if.pc + DW'($signed({id_if.imm24, 2'b00}));

    always_comb begin
        case (id_if.sel_src1)
            2'b01:   rn_fwd = wb_fwd_value_i;
            2'b10:   rn_fwd = mem_fwd_value_i;
            default: rn_fwd = id_if.val_rn;
        endcase
        case (id_if.sel_src2)
            2'b01:   rm_fwd = wb_fwd_value_i;
            2'b10:   rm_fwd = mem_fwd_value_i;
            default: rm_fwd = id_if.val_rm;
        endcase
    end

    // Operand 2: rotated imm8, zero-extended 12-bit memory offset, or shifted Rm.
    always_comb begin
        val2 = rm_fwd;
        if (id_if.immediate)
            val2 = ror(DW'(id_if.shift_operand[7:0]), 32'({id_if.shift_operand[11:8], 1'b0}));
        else if (id_if.mem_read_en || id_if.mem_write_en)
            val2 = DW'(id_if.shift_operand);
        else begin
            case (id_if.shift_operand[6:5])
                2'b00:   val2 = rm_fwd << id_if.shift_operand[11:7];
                2'b01:   val2 = rm_fwd >> id_if.shift_operand[11:7];
                2'b10:   val2 = $unsigned($signed(rm_fwd) >>> id_if.shift_operand[11:7]);
                default: val2 = ror(rm_fwd, 32'(id_if.shift_operand[11:7]));
            endcase
        end
    end

    // Subtracts are a + ~b + cin so that C is the ARM-style "not borrow".
    always_comb begin
        add_b   = val2;
        add_cin = 1'b0;
        case (id_if.alu_ctrl)
            OP_ADC:  add_cin = id_if.carry_in;
            OP_SUB:  begin add_b = ~val2; add_cin = 1'b1; end
            OP_SBC:  begin add_b = ~val2; add_cin = id_if.carry_in; end
            default: ;
        endcase
        add_sum = {1'b0, rn_fwd} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
        alu_res = '0;
        alu_c   = id_if.carry_in;
        alu_v   = 1'b0;
        case (id_if.alu_ctrl)
            OP_MOV: alu_res = val2;
            OP_MVN: alu_res = ~val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res = add_sum[DW-1:0];
                alu_c   = add_sum[DW];
                alu_v   = (rn_fwd[DW-1] == add_b[DW-1]) && (add_sum[DW-1] != rn_fwd[DW-1]);
            end
            OP_AND: alu_res = rn_fwd & val2;
            OP_ORR: alu_res = rn_fwd | val2;
            OP_EOR: alu_res = rn_fwd ^ val2;
            default: ;
        endcase
        alu_flags = {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
    end

    assign accept   = id_if.valid && !stall && !flush_i;
    assign id_if.stall = stall;

`ifdef EXE_STAGE_MUL_EN
    localparam int N  = DW / MUL_BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] mcand_q, mplier_q, acc_q, rn_q, mul_result;
    logic          accum_q, carry_q, m_rd_q, m_wr_q, m_wb_q, mul_done;
    logic [DW-1:0] part_w [MUL_BITS_PER_CYCLE+1];
    genvar gi;

    // One multiplier bit per stage of the chain; the multiplier shifts right each cycle.
    assign part_w[0] = acc_q;
    for (gi = 0; gi < MUL_BITS_PER_CYCLE; gi++) begin : g_pp
        assign part_w[gi+1] = part_w[gi] + (mplier_q[gi] ? (mcand_q << gi) : '0);
    end

    assign mul_done   = (state_q == BUSY) && (cnt_q == CW'(N - 1));
    assign mul_result = part_w[MUL_BITS_PER_CYCLE] + (accum_q ? rn_q : '0);
    assign stall      = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        if (flush_i)
            state_d = IDLE;
        else if (state_q == IDLE && accept && id_if.mul)
            state_d = BUSY;
        else if (mul_done)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            rn_q     <= '0;
            accum_q  <= 1'b0;
            carry_q  <= 1'b0;
            m_rd_q   <= 1'b0;
            m_wr_q   <= 1'b0;
            m_wb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_i)
                cnt_q <= '0;
            else if (accept && id_if.mul) begin
                mcand_q  <= rm_fwd;
                mplier_q <= id_if.val_rs;
                acc_q    <= '0;
                rn_q     <= rn_fwd;
                accum_q  <= id_if.accumulate;
                carry_q  <= id_if.carry_in;
                m_rd_q   <= id_if.mem_read_en;
                m_wr_q   <= id_if.mem_write_en;
                m_wb_q   <= id_if.wb_en;
                cnt_q    <= '0;
            end else if (state_q == BUSY) begin
                mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
                mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
                acc_q    <= part_w[MUL_BITS_PER_CYCLE];
                cnt_q    <= mul_done ? '0 : cnt_q + CW'(1);
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            wb_en_q        <= 1'b0;
            pc_q           <= '0;
            result_q       <= '0;
            val_rm_q       <= '0;
            dest_q         <= '0;
            status_q       <= '0;
        end else if (flush_i) begin
            valid_q        <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            wb_en_q        <= 1'b0;
`ifdef EXE_STAGE_MUL_EN
        end else if (mul_done) begin
            valid_q        <= 1'b1;
            result_q       <= mul_result;
            status_q       <= {mul_result[DW-1], mul_result == '0, carry_q, 1'b0};
            mem_read_en_q  <= m_rd_q;
            mem_write_en_q <= m_wr_q;
            wb_en_q        <= m_wb_q;
        end else if (accept && id_if.mul) begin
            valid_q        <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            wb_en_q        <= 1'b0;
            pc_q           <= id_if.pc;
            dest_q         <= id_if.dest;
            val_rm_q       <= rm_fwd;
`endif
        end else if (accept) begin
            valid_q        <= 1'b1;
            mem_read_en_q  <= id_if.mem_read_en;
            mem_write_en_q <= id_if.mem_write_en;
            wb_en_q        <= id_if.wb_en;
            pc_q           <= id_if.pc;
            result_q       <= alu_res;
            val_rm_q       <= rm_fwd;
            dest_q         <= id_if.dest;
            status_q       <= alu_flags;
        end else begin
            valid_q        <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            wb_en_q        <= 1'b0;
        end
    end

    assign valid_o        = valid_q;
    assign pc_o           = pc_q;
    assign mem_read_en_o  = mem_read_en_q;
    assign mem_write_en_o = mem_write_en_q;
    assign wb_en_o        = wb_en_q;
    assign dest_o         = dest_q;
    assign alu_result_o   = result_q;
    assign alu_status_o   = status_q;
    assign val_rm_o       = val_rm_q;
endmodule

// File: tb/tb_exe_stage_pipelined.sv
// Directed bench for exe_stage_pipelined; multiplier steps run when EXE_STAGE_MUL_EN is defined.
module tb_exe_stage_pipelined;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] mem_fwd = '0, wb_fwd = '0;
    logic [DW-1:0] branch_addr, pc_out, result, val_rm_out;
    logic          valid_out, rd_out, wr_out, wb_out;
    logic [3:0]    dest_out, status;
    int            total = 0;
    int            bad = 0;

    exe_stage_pipelined_if #(.DATA_WIDTH(DW)) id_bus ();

    exe_stage_pipelined #(.DATA_WIDTH(DW), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .id_if(id_bus.slave), .flush_i(flush),
        .mem_fwd_value_i(mem_fwd), .wb_fwd_value_i(wb_fwd),
        .branch_address_o(branch_addr), .valid_o(valid_out), .pc_o(pc_out),
        .mem_read_en_o(rd_out), .mem_write_en_o(wr_out), .wb_en_o(wb_out),
        .dest_o(dest_out), .alu_result_o(result), .alu_status_o(status),
        .val_rm_o(val_rm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_bus.valid = 1'b0;        id_bus.pc = '0;
        id_bus.mem_read_en = 1'b0;  id_bus.mem_write_en = 1'b0;
        id_bus.wb_en = 1'b0;        id_bus.immediate = 1'b0;
        id_bus.carry_in = 1'b0;     id_bus.shift_operand = '0;
        id_bus.alu_ctrl = '0;       id_bus.mul = 1'b0;
        id_bus.accumulate = 1'b0;   id_bus.val_rm = '0;
        id_bus.val_rn = '0;         id_bus.val_rs = '0;
        id_bus.imm24 = '0;          id_bus.dest = '0;
        id_bus.sel_src1 = '0;       id_bus.sel_src2 = '0;
        mem_fwd = '0;               wb_fwd = '0;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [DW-1:0] rn, input logic [DW-1:0] rm);
        clear_inputs();
        id_bus.valid = 1'b1;
        id_bus.alu_ctrl = op;
        id_bus.val_rn = rn;
        id_bus.val_rm = rm;
    endtask

    initial begin
        logic seen_valid;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        $display("txn reset");
        check("rst_valid", DW'(valid_out), 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_status", DW'(status), 32'h0);
        check("rst_stall", DW'(id_bus.stall), 32'h0);
        check("rst_wb_en", DW'(wb_out), 32'h0);
        check("rst_pc", pc_out, 32'h0);
        rst = 1'b0;

        alu_op(4'b0010, 32'd5, 32'd7);
        id_bus.wb_en = 1'b1; id_bus.dest = 4'd3; id_bus.pc = 32'h40;
        tick();
        $display("txn ADD 5+7");
        check("add_result", result, 32'd12);
        check("add_valid", DW'(valid_out), 32'h1);
        check("add_status", DW'(status), 32'h0);
        check("add_dest", DW'(dest_out), 32'h3);
        check("add_wb_en", DW'(wb_out), 32'h1);
        check("add_pc", pc_out, 32'h40);
        clear_inputs();
        tick();
        $display("txn idle");
        check("idle_valid", DW'(valid_out), 32'h0);
        check("idle_wb_en", DW'(wb_out), 32'h0);
        check("idle_hold", result, 32'd12);

        alu_op(4'b0100, 32'd0, 32'd0);
        id_bus.sel_src1 = 2'b10; id_bus.sel_src2 = 2'b01; mem_fwd = 32'd9; wb_fwd = 32'd4;
        tick();
        $display("txn SUB fwd MEM-WB");
        check("sub_fwd_result", result, 32'd5);
        check("sub_fwd_status", DW'(status), 32'h2);
        check("sub_fwd_rm", val_rm_out, 32'd4);
        id_bus.sel_src1 = 2'b11; id_bus.sel_src2 = 2'b11;
        id_bus.val_rn = 32'd20; id_bus.val_rm = 32'd3;
        tick();
        $display("txn SUB sel 11");
        check("sub_sel11_result", result, 32'd17);

        id_bus.pc = 32'h100; id_bus.imm24 = 24'hFFFFFF;
        #1;
        $display("txn branch back");
        check("br_back", branch_addr, 32'hFC);
        id_bus.imm24 = 24'h000010;
        #1;
        $display("txn branch fwd");
        check("br_fwd", branch_addr, 32'h140);

        alu_op(4'b0001, 32'd0, 32'd0);
        id_bus.immediate = 1'b1; id_bus.shift_operand = 12'h1FF;
        tick();
        $display("txn MOV imm");
        check("mov_imm_result", result, 32'hC000003F);
        check("mov_imm_status", DW'(status), 32'h8);

        alu_op(4'b0010, 32'd2, 32'd3);
        id_bus.shift_operand = 12'h200;
        tick();
        $display("txn ADD lsl4");
        check("add_lsl_result", result, 32'h32);

        alu_op(4'b0010, 32'd100, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("txn flush arriving");
        check("flush_valid", DW'(valid_out), 32'h0);
        check("flush_hold", result, 32'h32);
        clear_inputs();

`ifndef EXE_STAGE_MUL_EN
        alu_op(4'b0010, 32'd1, 32'd2);
        id_bus.mul = 1'b1; id_bus.accumulate = 1'b1; id_bus.val_rs = 32'd100;
        #1;
        check("nomul_stall", DW'(id_bus.stall), 32'h0);
        tick();
        $display("txn mul-flag as ALU");
        check("nomul_result", result, 32'd3);
        check("nomul_valid", DW'(valid_out), 32'h1);
        clear_inputs();
`else
        alu_op(4'b0000, 32'd0, 32'd6);
        id_bus.mul = 1'b1; id_bus.val_rs = 32'd7; id_bus.wb_en = 1'b1;
        id_bus.dest = 4'd5; id_bus.pc = 32'h80;
        tick();
        clear_inputs();
        id_bus.val_rm = 32'd99; id_bus.sel_src2 = 2'b10; mem_fwd = 32'd55;
        for (int i = 0; i < 32; i++) begin
            check("mul_busy_stall", DW'(id_bus.stall), 32'h1);
            check("mul_busy_valid", DW'(valid_out), 32'h0);
            tick();
        end
        $display("txn MUL 6*7");
        check("mul_result", result, 32'd42);
        check("mul_valid", DW'(valid_out), 32'h1);
        check("mul_stall_done", DW'(id_bus.stall), 32'h0);
        check("mul_status", DW'(status), 32'h0);
        check("mul_dest", DW'(dest_out), 32'h5);
        check("mul_wb_en", DW'(wb_out), 32'h1);
        check("mul_pc", pc_out, 32'h80);
        clear_inputs();
        tick();
        check("mul_valid_once", DW'(valid_out), 32'h0);

        alu_op(4'b0000, 32'd3, 32'hFFFFFFFF);
        id_bus.mul = 1'b1; id_bus.accumulate = 1'b1; id_bus.val_rs = 32'd2;
        id_bus.carry_in = 1'b1;
        tick();
        clear_inputs();
        repeat (32) tick();
        $display("txn MLA");
        check("mla_result", result, 32'h1);
        check("mla_status", DW'(status), 32'h2);
        check("mla_valid", DW'(valid_out), 32'h1);

        alu_op(4'b0000, 32'd0, 32'd6);
        id_bus.mul = 1'b1; id_bus.val_rs = 32'd7;
        tick();
        clear_inputs();
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("txn MUL flushed");
        check("mflush_stall", DW'(id_bus.stall), 32'h0);
        check("mflush_valid", DW'(valid_out), 32'h0);
        seen_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            seen_valid = seen_valid | valid_out;
        end
        check("mflush_no_result", DW'(seen_valid), 32'h0);
        alu_op(4'b0010, 32'd1, 32'd1);
        tick();
        $display("txn ADD after flush");
        check("post_flush_result", result, 32'd2);
        check("post_flush_valid", DW'(valid_out), 32'h1);

        alu_op(4'b0000, 32'd0, 32'd6);
        id_bus.mul = 1'b1; id_bus.val_rs = 32'd7; id_bus.wb_en = 1'b1;
        tick();
        clear_inputs();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        $display("txn reset mid-MUL");
        check("mrst_valid", DW'(valid_out), 32'h0);
        check("mrst_result", result, 32'h0);
        check("mrst_stall", DW'(id_bus.stall), 32'h0);
        check("mrst_wb_en", DW'(wb_out), 32'h0);
        tick();
        rst = 1'b0;
        alu_op(4'b0010, 32'd4, 32'd4);
        tick();
        $display("txn ADD after reset");
        check("post_rst_result", result, 32'd8);
        check("post_rst_valid", DW'(valid_out), 32'h1);
        clear_inputs();
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
